// File: rtl/aib_calib_pkg.sv
// rtl/aib_calib_pkg.sv - state encoding and per-channel config table for the AIB calibration sequencer
package aib_calib_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_RESET_HOLD = 4'd1,
    ST_CFG_WRITE  = 4'd2,
    ST_CONF_DONE  = 4'd3,
    ST_DLL_REQ    = 4'd4,
    ST_WAIT_XFER  = 4'd5,
    ST_LINK_UP    = 4'd6,
    ST_RETRY      = 4'd7,
    ST_FAIL       = 4'd8
  } calib_state_e;

  localparam int CHNL_ADDR_LSB = 11;
  localparam int CFG_TABLE_LEN = 4;

  localparam logic [CHNL_ADDR_LSB-1:0] CFG_OFFSET [CFG_TABLE_LEN] =
    '{11'h010, 11'h014, 11'h020, 11'h030};
  localparam logic [31:0] CFG_DATA [CFG_TABLE_LEN] =
    '{32'h0000_0001, 32'h0000_00A5, 32'h0001_0003, 32'h8000_0000};

endpackage

// File: rtl/aib_xfer_en_sync.sv
// rtl/aib_xfer_en_sync.sv - two-flop synchroniser for one asynchronous transfer-enable bus
module aib_xfer_en_sync #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/aib_link_calib_ctrl.sv
// rtl/aib_link_calib_ctrl.sv - multi-channel AIB calibration sequencer with timeout, retry and link monitoring
module aib_link_calib_ctrl
  import aib_calib_pkg::*;
#(
  parameter int NBR_CHNLS      = 24,
  parameter int ACTIVE_CHNLS   = 1,
  parameter int AVMM_AWIDTH    = 17,
  parameter int NUM_CFG_WRITES = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRY      = 3,
  parameter int SETTLE_CYCLES  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   auto_recal_en_i,
  output logic [AVMM_AWIDTH-1:0] avmm_address_o,
  output logic                   avmm_write_o,
  output logic [31:0]            avmm_writedata_o,
  output logic [3:0]             avmm_byteenable_o,
  input  logic                   avmm_waitrequest_i,
  output logic                   i_conf_done_o,
  output logic [NBR_CHNLS-1:0]   ns_adapter_rstn_o,
  output logic [NBR_CHNLS-1:0]   ns_mac_rdy_o,
  output logic [NBR_CHNLS-1:0]   ms_tx_dcc_dll_lock_req_o,
  output logic [NBR_CHNLS-1:0]   ms_rx_dcc_dll_lock_req_o,
  input  logic [NBR_CHNLS-1:0]   ms_tx_transfer_en_i,
  input  logic [NBR_CHNLS-1:0]   ms_rx_transfer_en_i,
  input  logic [NBR_CHNLS-1:0]   sl_tx_transfer_en_i,
  input  logic [NBR_CHNLS-1:0]   sl_rx_transfer_en_i,
  output logic [NBR_CHNLS-1:0]   tx_online_o,
  output logic [NBR_CHNLS-1:0]   rx_online_o,
  output logic                   calib_done_o,
  output logic                   calib_fail_o,
  output logic [1:0]             retry_cnt_o,
  output logic [3:0]             state_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2*SETTLE_CYCLES + 1);
  localparam int KW    = (CFG_TABLE_LEN > 1) ? $clog2(CFG_TABLE_LEN) : 1;
  localparam logic [NBR_CHNLS-1:0] ACTIVE_MASK = {NBR_CHNLS{1'b1}} >> (NBR_CHNLS - ACTIVE_CHNLS);

  calib_state_e         state, next_state;
  logic [CNT_W-1:0]     cnt;
  logic [5:0]           ch;
  logic [KW-1:0]        k;
  logic [1:0]           retry_cnt;
  logic [NBR_CHNLS-1:0] ms_tx_s, ms_rx_s, sl_tx_s, sl_rx_s, chnl_up, tx_up_q, rx_up_q;
  logic                 all_up, wr_done, last_k, last_ch, settled, seq_en;

  aib_xfer_en_sync #(.WIDTH(NBR_CHNLS)) u_sync_ms_tx (.clk(clk), .rst(rst), .d(ms_tx_transfer_en_i), .q(ms_tx_s));
  aib_xfer_en_sync #(.WIDTH(NBR_CHNLS)) u_sync_ms_rx (.clk(clk), .rst(rst), .d(ms_rx_transfer_en_i), .q(ms_rx_s));
  aib_xfer_en_sync #(.WIDTH(NBR_CHNLS)) u_sync_sl_tx (.clk(clk), .rst(rst), .d(sl_tx_transfer_en_i), .q(sl_tx_s));
  aib_xfer_en_sync #(.WIDTH(NBR_CHNLS)) u_sync_sl_rx (.clk(clk), .rst(rst), .d(sl_rx_transfer_en_i), .q(sl_rx_s));

  assign chnl_up = ms_tx_s & sl_tx_s & ms_rx_s & sl_rx_s;
  assign all_up  = &(chnl_up | ~ACTIVE_MASK);
  assign wr_done = (state == ST_CFG_WRITE) && !avmm_waitrequest_i;
  assign last_k  = (k == KW'(NUM_CFG_WRITES - 1));
  assign last_ch = (ch == 6'(ACTIVE_CHNLS - 1));
  assign settled = (cnt == CNT_W'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:       if (start_i) next_state = ST_RESET_HOLD;
      ST_RESET_HOLD: if (settled) next_state = ST_CFG_WRITE;
      ST_CFG_WRITE:  if (wr_done && last_k && last_ch) next_state = ST_CONF_DONE;
      ST_CONF_DONE:  if (cnt == CNT_W'(2*SETTLE_CYCLES - 1)) next_state = ST_DLL_REQ;
      ST_DLL_REQ:    next_state = ST_WAIT_XFER;
      // channel-up has priority over a coincident timeout
      ST_WAIT_XFER: begin
        if (all_up)                                      next_state = ST_LINK_UP;
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1))      next_state = ST_RETRY;
      end
      ST_LINK_UP:    if (!all_up && settled) next_state = auto_recal_en_i ? ST_RETRY : ST_FAIL;
      ST_RETRY:      next_state = (retry_cnt == 2'(MAX_RETRY)) ? ST_FAIL : ST_RESET_HOLD;
      ST_FAIL:       if (start_i) next_state = ST_RESET_HOLD;
      default:       next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      ch        <= '0;
      k         <= '0;
      retry_cnt <= '0;
      tx_up_q   <= '0;
      rx_up_q   <= '0;
    end else begin
      tx_up_q <= ms_tx_s & sl_tx_s & ACTIVE_MASK;
      rx_up_q <= ms_rx_s & sl_rx_s & ACTIVE_MASK;

      // in LINK_UP the counter is the link-loss debounce, so any up cycle restarts it
      if (next_state != state || (state == ST_LINK_UP && all_up))
        cnt <= '0;
      else if (state inside {ST_RESET_HOLD, ST_CONF_DONE, ST_WAIT_XFER, ST_LINK_UP})
        cnt <= cnt + CNT_W'(1);

      if (state != ST_CFG_WRITE) begin
        ch <= '0;
        k  <= '0;
      end else if (wr_done) begin
        if (last_k) begin
          k  <= '0;
          ch <= ch + 6'd1;
        end else begin
          k  <= k + KW'(1);
        end
      end

      if (next_state == ST_LINK_UP && state != ST_LINK_UP)
        retry_cnt <= '0;
      else if (state == ST_FAIL && start_i)
        retry_cnt <= '0;
      else if (state == ST_RETRY && retry_cnt != 2'(MAX_RETRY))
        retry_cnt <= retry_cnt + 2'd1;
    end
  end

  always_comb begin
    avmm_write_o      = 1'b0;
    avmm_address_o    = '0;
    avmm_writedata_o  = '0;
    avmm_byteenable_o = 4'h0;
    seq_en            = state inside {ST_DLL_REQ, ST_WAIT_XFER, ST_LINK_UP};
    if (state == ST_CFG_WRITE) begin
      avmm_write_o      = 1'b1;
      avmm_address_o    = AVMM_AWIDTH'({ch, CFG_OFFSET[k]});
      avmm_writedata_o  = CFG_DATA[k];
      avmm_byteenable_o = 4'hF;
    end
    i_conf_done_o            = seq_en || (state == ST_CONF_DONE);
    ns_adapter_rstn_o        = (seq_en || (state == ST_CONF_DONE && cnt >= CNT_W'(SETTLE_CYCLES))) ? ACTIVE_MASK : '0;
    ns_mac_rdy_o             = ns_adapter_rstn_o;
    ms_tx_dcc_dll_lock_req_o = seq_en ? ACTIVE_MASK : '0;
    ms_rx_dcc_dll_lock_req_o = seq_en ? ACTIVE_MASK : '0;
    tx_online_o              = (state == ST_LINK_UP) ? tx_up_q : '0;
    rx_online_o              = (state == ST_LINK_UP) ? rx_up_q : '0;
    calib_done_o             = (state == ST_LINK_UP);
    calib_fail_o             = (state == ST_FAIL);
    retry_cnt_o              = retry_cnt;
    state_o                  = state;
  end

endmodule
